// File: rtl/ssd_scan_driver_if.sv
// Bundle between the datapath/refresh counter and the seven-segment scan driver.
// The master side supplies the digit select and display value; the slave side drives the pins.
interface ssd_scan_driver_if;
    logic [2:0]  ss_counter;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        lz_blank_en;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp_n;
    logic        frame_tick;

    modport master (
        output ss_counter, load, data_in, dp_in, lz_blank_en,
        input  anode, cathode, dp_n, frame_tick
    );

    modport slave (
        input  ss_counter, load, data_in, dp_in, lz_blank_en,
        output anode, cathode, dp_n, frame_tick
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// Eight-digit seven-segment scan driver: anti-ghost blanking between digits,
// tear-free value commit on the 7->0 frame boundary, optional leading-zero suppression.
module ssd_scan_driver #(
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    ssd_scan_driver_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Bit i set means digit i and every digit above it hold zero; digit 0 is never flagged.
    function automatic logic [7:0] lz_mask(input logic [31:0] value);
        logic [7:0] mask;
        logic       zero_above;
        mask       = 8'h00;
        zero_above = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_above = zero_above & (value[4*i +: 4] == 4'h0);
            mask[i]    = zero_above;
        end
        return mask;
    endfunction

    logic [2:0]       ss_q_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      disp_r;
    logic [7:0]       dp_r;
    logic [31:0]      pend_data_r;
    logic [7:0]       pend_dp_r;
    logic             pend_valid_r;
    logic [7:0]       anode_r;
    logic [6:0]       cathode_r;
    logic             dp_n_r;
    logic             frame_tick_r;

    logic             change_s;
    logic             boundary_s;
    logic [3:0]       nibble_s;
    logic [7:0]       lz_mask_s;
    logic [6:0]       seg_s;
    logic [7:0]       anode_drive_s;
    logic             dp_drive_s;

    // Select-change detection and per-digit segment pattern for the currently held select.
    always_comb begin
        change_s      = (bus.ss_counter != ss_q_r);
        boundary_s    = change_s && (ss_q_r == 3'd7) && (bus.ss_counter == 3'd0);
        nibble_s      = disp_r[{ss_q_r, 2'b00} +: 4];
        lz_mask_s     = lz_mask(disp_r);
        anode_drive_s = ~(8'b0000_0001 << ss_q_r);
        dp_drive_s    = ~dp_r[ss_q_r];
        if (bus.lz_blank_en && lz_mask_s[ss_q_r]) begin
            seg_s = 7'h7F;
        end else begin
            seg_s = hex_decode(nibble_s);
        end
    end

    // Scan FSM: blank on every select change, then drive the digit once the hold-off expires.
    // The expiring BLANK cycle already drives, so the dark window is exactly BLANK_CYCLES long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q_r    <= 3'd0;
            state_r   <= ST_BLANK;
            cnt_r     <= CNT_LOAD;
            anode_r   <= 8'hFF;
            cathode_r <= 7'h7F;
            dp_n_r    <= 1'b1;
        end else begin
            ss_q_r <= bus.ss_counter;
            if (change_s) begin
                state_r   <= ST_BLANK;
                cnt_r     <= CNT_LOAD;
                anode_r   <= 8'hFF;
                cathode_r <= 7'h7F;
                dp_n_r    <= 1'b1;
            end else begin
                case (state_r)
                    ST_BLANK: begin
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            state_r   <= ST_DRIVE;
                            anode_r   <= anode_drive_s;
                            cathode_r <= seg_s;
                            dp_n_r    <= dp_drive_s;
                        end else begin
                            cnt_r     <= cnt_r - CNT_ONE;
                            anode_r   <= 8'hFF;
                            cathode_r <= 7'h7F;
                            dp_n_r    <= 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        anode_r   <= anode_drive_s;
                        cathode_r <= seg_s;
                        dp_n_r    <= dp_drive_s;
                    end
                    default: begin
                        state_r   <= ST_BLANK;
                        cnt_r     <= CNT_LOAD;
                        anode_r   <= 8'hFF;
                        cathode_r <= 7'h7F;
                        dp_n_r    <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Pending capture and frame-boundary commit; a load on the boundary itself bypasses pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_r       <= 32'h0000_0000;
            dp_r         <= 8'h00;
            pend_data_r  <= 32'h0000_0000;
            pend_dp_r    <= 8'h00;
            pend_valid_r <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= 1'b0;
            if (boundary_s && bus.load) begin
                disp_r       <= bus.data_in;
                dp_r         <= bus.dp_in;
                pend_valid_r <= 1'b0;
                frame_tick_r <= 1'b1;
            end else if (boundary_s && pend_valid_r) begin
                disp_r       <= pend_data_r;
                dp_r         <= pend_dp_r;
                pend_valid_r <= 1'b0;
                frame_tick_r <= 1'b1;
            end else if (bus.load) begin
                pend_data_r  <= bus.data_in;
                pend_dp_r    <= bus.dp_in;
                pend_valid_r <= 1'b1;
            end
        end
    end

    assign bus.anode      = anode_r;
    assign bus.cathode    = cathode_r;
    assign bus.dp_n       = dp_n_r;
    assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: directed scenarios plus randomized scanning
// against a cycle-level reference model built from the display rules.
module tb_ssd_scan_driver;

    localparam int BC = 4;
    localparam logic [16:0] BLANK_ALL = {8'hFF, 7'h7F, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ssd_scan_driver_if bus ();

    ssd_scan_driver #(.BLANK_CYCLES(BC), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // reference model state
    logic [2:0]  m_sel;
    int          m_since;
    logic [31:0] m_disp;
    logic [7:0]  m_dp;
    logic [31:0] m_pend;
    logic [7:0]  m_pend_dp;
    logic        m_pend_v;
    logic [16:0] exp_all;

    function automatic logic [16:0] got();
        return {bus.anode, bus.cathode, bus.dp_n, bus.frame_tick};
    endfunction

    task automatic model_reset();
        m_sel     = 3'd0;
        m_since   = 0;
        m_disp    = 32'h0;
        m_dp      = 8'h0;
        m_pend    = 32'h0;
        m_pend_dp = 8'h0;
        m_pend_v  = 1'b0;
        exp_all   = BLANK_ALL;
    endtask

    // Apply inputs for one clock, advance the model, and leave the bench 1 time unit past the edge.
    task automatic tick(input logic [2:0] sel, input logic ld, input logic [31:0] d, input logic [7:0] dp);
        logic        commit;
        int          s;
        logic [31:0] upper;
        logic [6:0]  seg;
        bus.ss_counter = sel;
        bus.load       = ld;
        bus.data_in    = d;
        bus.dp_in      = dp;
        @(posedge clk);
        commit = 1'b0;
        if (sel != m_sel && m_sel == 3'd7 && sel == 3'd0) begin
            if (ld) begin
                m_disp = d; m_dp = dp; commit = 1'b1; m_pend_v = 1'b0;
            end else if (m_pend_v) begin
                m_disp = m_pend; m_dp = m_pend_dp; commit = 1'b1; m_pend_v = 1'b0;
            end
        end else if (ld) begin
            m_pend = d; m_pend_dp = dp; m_pend_v = 1'b1;
        end
        m_since = (sel != m_sel) ? 0 : ((m_since < 1000) ? m_since + 1 : m_since);
        m_sel   = sel;
        if (m_since < BC) begin
            exp_all = {8'hFF, 7'h7F, 1'b1, commit};
        end else begin
            s     = int'(sel);
            upper = m_disp / (32'd1 << (4 * s));
            seg   = (bus.lz_blank_en && s != 0 && upper == 32'd0) ? 7'h7F : seg_tab[upper % 16];
            exp_all = {~(8'd1 << s), seg, ~m_dp[s], commit};
        end
        #1;
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.ss_counter = 3'(i);
            @(posedge clk); #1;
            total_cnt++;
            if (got() !== BLANK_ALL) $display("FAIL reset_outputs i=%0d got=%h exp=%h", i, got(), BLANK_ALL);
            else pass_cnt++;
        end
        bus.ss_counter = 3'd0;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_blanking();
        int blank_n;
        tick(3'd0, 1'b1, 32'h0000_0008, 8'h00);
        for (int c = 0; c < 6; c++) begin
            tick(3'd7, 1'b0, 32'h0, 8'h0);
            total_cnt++;
            if (got() !== exp_all) $display("FAIL blank_pre c=%0d got=%h exp=%h", c, got(), exp_all);
            else pass_cnt++;
        end
        tick(3'd0, 1'b0, 32'h0, 8'h0);
        total_cnt++;
        if (bus.frame_tick !== 1'b1) $display("FAIL blank_commit_tick got=%b exp=1", bus.frame_tick);
        else pass_cnt++;
        blank_n = 0;
        for (int i = 0; i < 10 && bus.anode === 8'hFF; i++) begin
            blank_n++;
            tick(3'd0, 1'b0, 32'h0, 8'h0);
        end
        total_cnt++;
        if (blank_n != BC) $display("FAIL blank_len got=%0d exp=%0d", blank_n, BC);
        else pass_cnt++;
        total_cnt++;
        if ({bus.anode, bus.cathode} !== {8'hFE, 7'b0000000})
            $display("FAIL blank_digit0 got=%h/%b exp=fe/0000000", bus.anode, bus.cathode);
        else pass_cnt++;
    endtask

    task automatic test_tear_free();
        tick(3'd0, 1'b1, 32'h1234_5678, 8'h00);
        tick(3'd7, 1'b0, 32'h0, 8'h0);
        tick(3'd0, 1'b0, 32'h0, 8'h0);
        for (int d = 1; d < 8; d++) begin
            for (int c = 0; c < 6; c++) begin
                tick(3'(d), (d == 3 && c == 2), 32'hDEAD_BEEF, 8'h00);
                total_cnt++;
                if (got() !== exp_all) $display("FAIL tear_scan d=%0d c=%0d got=%h exp=%h", d, c, got(), exp_all);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bus.cathode !== 7'b1111001) $display("FAIL tear_old_digit7 got=%b exp=1111001", bus.cathode);
        else pass_cnt++;
        tick(3'd0, 1'b0, 32'h0, 8'h0);
        total_cnt++;
        if (bus.frame_tick !== 1'b1) $display("FAIL tear_tick got=%b exp=1", bus.frame_tick);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            tick(3'd0, 1'b0, 32'h0, 8'h0);
            total_cnt++;
            if (got() !== exp_all) $display("FAIL tear_post c=%0d got=%h exp=%h", c, got(), exp_all);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.cathode !== 7'b0001110) $display("FAIL tear_new_digit0 got=%b exp=0001110", bus.cathode);
        else pass_cnt++;
        repeat (5) tick(3'd7, 1'b0, 32'h0, 8'h0);
        total_cnt++;
        if (bus.cathode !== 7'b0100001) $display("FAIL tear_new_digit7 got=%b exp=0100001", bus.cathode);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        tick(3'd0, 1'b1, 32'h0000_00A0, 8'h02);
        total_cnt++;
        if (bus.frame_tick !== 1'b1) $display("FAIL simul_tick got=%b exp=1", bus.frame_tick);
        else pass_cnt++;
        tick(3'd0, 1'b0, 32'h0, 8'h0);
        total_cnt++;
        if (bus.frame_tick !== 1'b0) $display("FAIL simul_tick_width got=%b exp=0", bus.frame_tick);
        else pass_cnt++;
        repeat (5) tick(3'd1, 1'b0, 32'h0, 8'h0);
        total_cnt++;
        if ({bus.anode, bus.cathode, bus.dp_n} !== {8'hFD, 7'b0001000, 1'b0})
            $display("FAIL simul_digit1 got=%h/%b/%b exp=fd/0001000/0", bus.anode, bus.cathode, bus.dp_n);
        else pass_cnt++;
    endtask

    task automatic test_lz();
        logic [6:0] want [8];
        want = '{7'b0010010, 7'b1000000, 7'b1111001, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        bus.lz_blank_en = 1'b1;
        tick(3'd1, 1'b1, 32'h0000_0105, 8'h00);
        tick(3'd7, 1'b0, 32'h0, 8'h0);
        tick(3'd0, 1'b0, 32'h0, 8'h0);
        for (int d = 0; d < 8; d++) begin
            repeat (5) tick(3'(d), 1'b0, 32'h0, 8'h0);
            total_cnt++;
            if ({bus.anode, bus.cathode} !== {~(8'd1 << d), want[d]})
                $display("FAIL lz_0105 d=%0d got=%h/%b exp=%h/%b", d, bus.anode, bus.cathode, ~(8'd1 << d), want[d]);
            else pass_cnt++;
        end
        tick(3'd7, 1'b1, 32'h0000_0000, 8'h00);
        for (int d = 0; d < 8; d++) begin
            repeat (5) tick(3'(d), 1'b0, 32'h0, 8'h0);
            total_cnt++;
            if (bus.cathode !== ((d == 0) ? 7'b1000000 : 7'h7F))
                $display("FAIL lz_zero d=%0d got=%b", d, bus.cathode);
            else pass_cnt++;
        end
        bus.lz_blank_en = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] sel;
        int         hold;
        logic       ld;
        for (int seg = 0; seg < 300; seg++) begin
            sel  = ($urandom_range(0, 9) < 4) ? m_sel + 3'd1 : 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 8);
            bus.lz_blank_en = 1'($urandom_range(0, 1));
            for (int c = 0; c < hold; c++) begin
                ld = ($urandom_range(0, 9) < 2);
                tick(sel, ld, $urandom, 8'($urandom));
                total_cnt++;
                if (got() !== exp_all) $display("FAIL random seg=%0d c=%0d got=%h exp=%h", seg, c, got(), exp_all);
                else pass_cnt++;
            end
        end
        bus.lz_blank_en = 1'b0;
    endtask

    task automatic test_async_reset();
        tick(3'd2, 1'b0, 32'h0, 8'h0);
        repeat (5) tick(3'd2, 1'b0, 32'h0, 8'h0);
        tick(3'd2, 1'b1, 32'hFFFF_FFFF, 8'hFF);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total_cnt++;
        if (got() !== BLANK_ALL) $display("FAIL async_blank got=%h exp=%h", got(), BLANK_ALL);
        else pass_cnt++;
        #2 rst = 1'b0;
        model_reset();
        repeat (3) tick(3'd7, 1'b0, 32'h0, 8'h0);
        tick(3'd0, 1'b0, 32'h0, 8'h0);
        total_cnt++;
        if (bus.frame_tick !== 1'b0) $display("FAIL async_no_tick got=%b exp=0", bus.frame_tick);
        else pass_cnt++;
        repeat (5) tick(3'd0, 1'b0, 32'h0, 8'h0);
        total_cnt++;
        if (got() !== exp_all || bus.cathode !== 7'b1000000)
            $display("FAIL async_digit0 got=%h exp=%h", got(), exp_all);
        else pass_cnt++;
    endtask

    initial begin
        rst             = 1'b1;
        bus.ss_counter  = 3'd0;
        bus.load        = 1'b0;
        bus.data_in     = 32'h0;
        bus.dp_in       = 8'h0;
        bus.lz_blank_en = 1'b0;
        model_reset();
        test_reset();
        test_blanking();
        test_tear_free();
        test_simultaneous();
        test_lz();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Eight-digit seven-segment scan driver, directly downstream of the refresh counter.
- Consumes the counter's 3-bit digit select (ss_counter) and a 32-bit display value supplied by the datapath.
- Drives active-low anodes, cathodes and decimal point.
- Provides tear-free frame-boundary value updates, anti-ghosting blanking between digits, and optional leading-zero suppression.

Parameters:
- BLANK_CYCLES, 16, clk cycles all anodes are held off after each digit-select change; legal range 1..255.
- CNT_W, 8, width of the blanking down-counter; must hold BLANK_CYCLES-1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- ss_counter  input  3  digit select from refresh counter; 0 = least significant digit
- load  input  1  one-cycle strobe; capture data_in/dp_in as pending value
- data_in  input  32  eight hex nibbles; digit i = data_in[4i+3:4i]
- dp_in  input  8  decimal point per digit, 1 = lit
- lz_blank_en  input  1  1 = suppress leading zero digits
- anode  output  8  active-low digit enables
- cathode  output  7  active-low segments {g,f,e,d,c,b,a}
- dp_n  output  1  active-low decimal point
- frame_tick  output  1  one-cycle pulse when a pending value is committed

Behaviour:
- Reset values (asynchronous, active-high):
  - anode=8'hFF, cathode=7'h7F, dp_n=1, frame_tick=0.
  - Display register = 0, dp register = 0, pending_valid = 0.
  - ss_q = 0, state = BLANK, cnt = BLANK_CYCLES-1.
- All outputs are registered.
- Change detection:
  - ss_q <= ss_counter every cycle.
  - change = (ss_counter != ss_q).
- FSM states BLANK and DRIVE:
  - Any state, change=1: next state BLANK, cnt <= BLANK_CYCLES-1, anode <= 8'hFF, dp_n <= 1, cathode <= 7'h7F.
  - BLANK, no change: if cnt==0 go to DRIVE, else cnt decrements. Outputs stay blanked.
  - DRIVE, no change: anode <= ~(8'b1 << ss_q). cathode <= hex decode of display nibble ss_q. dp_n <= ~dp_reg[ss_q].
  - Net effect: after the edge that observes a select change, anodes are off for exactly BLANK_CYCLES cycles, then the new digit is driven.
- Hex decode (gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011
  - C=1000110, D=0100001, E=0000110, F=0001110
- Leading-zero suppression (lz_blank_en=1):
  - Digit i (i>=1) is blanked if nibbles 7..i of the display register are all zero. Blanked means cathode=7'h7F; its anode is still asserted.
  - Digit 0 is never suppressed; value 0 shows a single "0".
  - dp_n follows dp_reg regardless of suppression.
- Pending / commit:
  - load=1 captures data_in and dp_in into the pending registers and sets pending_valid. A later load before commit overwrites the pending value; last one wins.
  - Frame boundary is the cycle with change=1, ss_q==7 and ss_counter==0.
  - At a boundary with pending_valid=1: display/dp <= pending, pending_valid <= 0, frame_tick <= 1.
  - Load and boundary in the same cycle: data_in/dp_in commit directly and frame_tick pulses.
  - No boundary: the display register is untouched.
  - frame_tick is high for exactly one cycle per commit.
- ss_counter jumping by more than 1, or stepping backwards, is treated as a normal change. Only the transition 7 to 0 counts as a boundary.
- Reset asserted mid-operation: outputs blank immediately (asynchronously) and the pending value is discarded.

Test Plan:
- Reset: hold rst, toggle ss_counter -> anode=8'hFF, cathode=7'h7F, dp_n=1, frame_tick=0 throughout.
- Blanking timing: BLANK_CYCLES=4, display=32'h0000_0008, ss_counter 7->0 -> anode=8'hFF for exactly 4 cycles, then anode=8'hFE, cathode=7'b0000000.
- Tear-free update: display 32'h1234_5678, load 32'hDEAD_BEEF while ss_counter=3 -> digits keep old value until the 7->0 transition. frame_tick pulses once there, after which digit 7 shows D=0100001 and digit 0 shows F=0001110.
- Simultaneous load and boundary: load 32'h0000_00A0 with dp_in=8'h02 on the 7->0 change cycle -> frame_tick=1 that cycle's next edge. Digit 1 then shows A=0001000 with dp_n=0.
- Leading-zero suppression: lz_blank_en=1, display 32'h0000_0105 -> digits 7..3 have cathode=7'h7F; digit 2=1111001, digit 1=1000000, digit 0=0010010. Value 0 -> only digit 0 lit with 1000000.
- Async reset mid-DRIVE: assert rst between edges with a pending value -> outputs blank without a clock edge. After release, next boundary produces no frame_tick.
